// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits, optional parity,
// 1 or 2 stop bits, valid/ready input handshake with gap-free back-to-back frames.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 dout
);

    if (PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_params
        $fatal(1, "uart_tx_param: illegal parameter set");
    end

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_parity;
    logic                  r_dout;

    state_t                w_state_nxt;
    logic [BAUD_W-1:0]     w_baud_nxt;
    logic [BIT_W-1:0]      w_bit_nxt;
    logic [DATA_BITS-1:0]  w_shift_nxt;
    logic                  w_parity_nxt;
    logic                  w_dout_nxt;
    logic                  w_tx_ready;
    logic                  w_tx_busy;

    logic [DATA_BITS-1:0]  w_shifted;
    logic                  w_cur_bit;
    logic                  w_next_bit;
    logic                  w_parity_in;
    logic                  w_baud_last;

    // w_cur_bit is the bit on the line now, w_next_bit the one after the shift.
    if (LSB_FIRST != 0) begin : g_lsb_first
        assign w_shifted  = {1'b0, r_shift[DATA_BITS-1:1]};
        assign w_cur_bit  = r_shift[0];
        assign w_next_bit = r_shift[1];
    end else begin : g_msb_first
        assign w_shifted  = {r_shift[DATA_BITS-2:0], 1'b0};
        assign w_cur_bit  = r_shift[DATA_BITS-1];
        assign w_next_bit = r_shift[DATA_BITS-2];
    end

    assign w_parity_in = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
    assign w_baud_last = (r_baud_cnt == BAUD_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_nxt  = r_state;
        w_baud_nxt   = w_baud_last ? '0 : r_baud_cnt + 1'b1;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_dout_nxt   = r_dout;
        w_tx_ready   = 1'b0;
        w_tx_busy    = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_tx_ready = 1'b1;
                w_tx_busy  = 1'b0;
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                w_dout_nxt = 1'b1;
            end
            S_START: begin
                if (w_baud_last) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                    w_dout_nxt  = w_cur_bit;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_dout_nxt  = r_parity;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_dout_nxt  = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        w_shift_nxt = w_shifted;
                        w_dout_nxt  = w_next_bit;
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_last) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = '0;
                    w_dout_nxt  = 1'b1;
                end
            end
            S_STOP: begin
                w_tx_ready = w_baud_last && (r_bit_cnt == STOP_LAST);
                if (w_baud_last) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                    w_dout_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_dout_nxt  = 1'b1;
            end
        endcase

        // Accept overrides the stop-bit exit so a waiting word starts with no idle gap.
        if (tx_valid && w_tx_ready) begin
            w_state_nxt  = S_START;
            w_shift_nxt  = tx_data;
            w_parity_nxt = w_parity_in;
            w_baud_nxt   = '0;
            w_bit_nxt    = '0;
            w_dout_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_dout     <= 1'b1;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values.
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_dout     <= w_dout_nxt;
        end
    end

    assign tx_ready = w_tx_ready;
    assign tx_busy  = w_tx_busy;
    assign dout     = r_dout;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter sets at CLKS_PER_BIT=4,
// selected one at a time, with hand-computed expected serial waveforms.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       tb_valid;
    logic [7:0] tb_data;

    logic [3:0] w_valid;
    logic [3:0] w_ready;
    logic [3:0] w_busy;
    logic [3:0] w_dout;
    logic       obs_ready;
    logic       obs_busy;
    logic       obs_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign w_valid[0] = tb_valid && (sel == 2'd0);
    assign w_valid[1] = tb_valid && (sel == 2'd1);
    assign w_valid[2] = tb_valid && (sel == 2'd2);
    assign w_valid[3] = tb_valid && (sel == 2'd3);

    assign obs_ready = w_ready[sel];
    assign obs_busy  = w_busy[sel];
    assign obs_dout  = w_dout[sel];

    // Defaults: 8N1, LSB first.
    uart_tx_param #(.CLKS_PER_BIT(4)) u_def (
        .clk(clk), .rst(rst), .tx_valid(w_valid[0]), .tx_data(tb_data),
        .tx_ready(w_ready[0]), .tx_busy(w_busy[0]), .dout(w_dout[0]));

    uart_tx_param #(.CLKS_PER_BIT(4), .PARITY(2)) u_even (
        .clk(clk), .rst(rst), .tx_valid(w_valid[1]), .tx_data(tb_data),
        .tx_ready(w_ready[1]), .tx_busy(w_busy[1]), .dout(w_dout[1]));

    uart_tx_param #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_odd (
        .clk(clk), .rst(rst), .tx_valid(w_valid[2]), .tx_data(tb_data),
        .tx_ready(w_ready[2]), .tx_busy(w_busy[2]), .dout(w_dout[2]));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .tx_valid(w_valid[3]), .tx_data(tb_data[6:0]),
        .tx_ready(w_ready[3]), .tx_busy(w_busy[3]), .dout(w_dout[3]));

    // Presents a word, waits (bounded) for ready, returns 1 unit after the accept edge.
    task automatic send_word(input logic [7:0] d, input logic keep);
        logic got;
        got      = 1'b0;
        tb_data  = d;
        tb_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (obs_ready) got = 1'b1;
        end
        total++;
        if (got !== 1'b1) begin
            bad++;
            $display("FAIL send_ready_wait got=%b required=1", got);
        end
        @(posedge clk);
        #1;
        if (!keep) tb_valid = 1'b0;
    endtask

    // Samples dout/busy once per cycle at the falling edge; optional input changes
    // are applied just after the rising edge following sample ev_a / ev_b.
    task automatic capture(input int n,
                           input int ev_a, input logic va, input logic [7:0] da,
                           input int ev_b, input logic vb, input logic [7:0] db,
                           output logic [0:199] line, output logic [0:199] busy);
        line = '1;
        busy = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            line[k] = obs_dout;
            busy[k] = obs_busy;
            if (k == ev_a) begin
                @(posedge clk);
                #1;
                tb_valid = va;
                tb_data  = da;
            end
            if (k == ev_b) begin
                @(posedge clk);
                #1;
                tb_valid = vb;
                tb_data  = db;
            end
        end
    endtask

    task automatic test_reset;
        rst      = 1'b0;
        sel      = 2'd0;
        tb_valid = 1'b0;
        tb_data  = 8'h00;
        #1 rst = 1'b1;
        #2;
        total++;
        if (w_dout !== 4'hF) begin
            bad++;
            $display("FAIL reset_dout got=%b required=1111", w_dout);
        end
        total++;
        if (w_ready !== 4'hF) begin
            bad++;
            $display("FAIL reset_ready got=%b required=1111", w_ready);
        end
        total++;
        if (w_busy !== 4'h0) begin
            bad++;
            $display("FAIL reset_busy got=%b required=0000", w_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_default;
        logic [0:199] line, busy;
        logic [0:9]   exp;
        logic [3:0]   got;
        exp = 10'b0_10100101_1;
        sel = 2'd0;
        send_word(8'hA5, 1'b0);
        capture(41, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, line, busy);
        for (int b = 0; b < 10; b++) begin
            got = line[b*4 +: 4];
            total++;
            if (got !== {4{exp[b]}}) begin
                bad++;
                $display("FAIL default_bit%0d got=%b required=%b", b, got, {4{exp[b]}});
            end
        end
        total++;
        if (busy[0 +: 40] !== {40{1'b1}}) begin
            bad++;
            $display("FAIL default_busy_frame got=%h required=all ones", busy[0 +: 40]);
        end
        total++;
        if ({busy[40], line[40], obs_ready} !== 3'b011) begin
            bad++;
            $display("FAIL default_end busy/dout/ready got=%b required=011",
                     {busy[40], line[40], obs_ready});
        end
    endtask

    task automatic test_parity;
        logic [0:199] line, busy;
        logic [0:10]  exp_e;
        logic [0:11]  exp_o;
        logic [3:0]   got;

        exp_e = 11'b0_10100101_0_1;
        sel   = 2'd1;
        send_word(8'hA5, 1'b0);
        capture(45, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, line, busy);
        for (int b = 0; b < 11; b++) begin
            got = line[b*4 +: 4];
            total++;
            if (got !== {4{exp_e[b]}}) begin
                bad++;
                $display("FAIL even_a5_bit%0d got=%b required=%b", b, got, {4{exp_e[b]}});
            end
        end
        total++;
        if ({busy[43], busy[44]} !== 2'b10) begin
            bad++;
            $display("FAIL even_a5_len busy[43:44] got=%b required=10", {busy[43], busy[44]});
        end

        exp_o = 12'b0_10100101_1_11;
        sel   = 2'd2;
        send_word(8'hA5, 1'b0);
        capture(49, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, line, busy);
        for (int b = 0; b < 12; b++) begin
            got = line[b*4 +: 4];
            total++;
            if (got !== {4{exp_o[b]}}) begin
                bad++;
                $display("FAIL odd_a5_bit%0d got=%b required=%b", b, got, {4{exp_o[b]}});
            end
        end
        total++;
        if ({busy[47], busy[48]} !== 2'b10) begin
            bad++;
            $display("FAIL odd_a5_len busy[47:48] got=%b required=10", {busy[47], busy[48]});
        end

        exp_o = 12'b0_10000000_0_11;
        send_word(8'h01, 1'b0);
        capture(49, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, line, busy);
        for (int b = 0; b < 12; b++) begin
            got = line[b*4 +: 4];
            total++;
            if (got !== {4{exp_o[b]}}) begin
                bad++;
                $display("FAIL odd_01_bit%0d got=%b required=%b", b, got, {4{exp_o[b]}});
            end
        end
    endtask

    task automatic test_msb_first;
        logic [0:199] line, busy;
        logic [0:8]   exp;
        logic [3:0]   got;
        exp = 9'b0_1000001_1;
        sel = 2'd3;
        send_word(8'h41, 1'b0);
        capture(37, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, line, busy);
        for (int b = 0; b < 9; b++) begin
            got = line[b*4 +: 4];
            total++;
            if (got !== {4{exp[b]}}) begin
                bad++;
                $display("FAIL msb_41_bit%0d got=%b required=%b", b, got, {4{exp[b]}});
            end
        end
        total++;
        if ({busy[35], busy[36]} !== 2'b10) begin
            bad++;
            $display("FAIL msb_len busy[35:36] got=%b required=10", {busy[35], busy[36]});
        end
    endtask

    task automatic test_back_to_back;
        logic [0:199] line, busy;
        logic [0:19]  exp;
        logic [3:0]   got;
        exp = 20'b0_10101010_1_0_01010101_1;
        sel = 2'd0;
        send_word(8'h55, 1'b1);
        tb_data = 8'hAA;
        // Valid is dropped just after the edge that ends frame one (second accept).
        capture(81, 39, 1'b0, 8'hAA, -1, 1'b0, 8'h00, line, busy);
        for (int b = 0; b < 20; b++) begin
            got = line[b*4 +: 4];
            total++;
            if (got !== {4{exp[b]}}) begin
                bad++;
                $display("FAIL b2b_bit%0d got=%b required=%b", b, got, {4{exp[b]}});
            end
        end
        total++;
        if (busy[0 +: 80] !== {80{1'b1}}) begin
            bad++;
            $display("FAIL b2b_busy_gap got=%h required=all ones", busy[0 +: 80]);
        end
        total++;
        if ({busy[80], line[80]} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_end busy/dout got=%b required=01", {busy[80], line[80]});
        end
    endtask

    task automatic test_ignore_while_busy;
        logic [0:199] line, busy;
        logic [0:9]   exp;
        logic [3:0]   got;
        exp = 10'b0_00111100_1;
        sel = 2'd0;
        send_word(8'h3C, 1'b0);
        capture(44, 10, 1'b1, 8'hFF, 20, 1'b0, 8'h00, line, busy);
        for (int b = 0; b < 10; b++) begin
            got = line[b*4 +: 4];
            total++;
            if (got !== {4{exp[b]}}) begin
                bad++;
                $display("FAIL ignore_bit%0d got=%b required=%b", b, got, {4{exp[b]}});
            end
        end
        total++;
        if ({busy[40 +: 4], line[40 +: 4]} !== 8'b0000_1111) begin
            bad++;
            $display("FAIL ignore_after busy/dout got=%b required=00001111",
                     {busy[40 +: 4], line[40 +: 4]});
        end
    endtask

    task automatic test_async_reset;
        logic [0:199] line, busy;
        sel = 2'd0;
        send_word(8'h00, 1'b0);
        // Sample 17 lies inside data bit 3.
        capture(18, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, line, busy);
        total++;
        if ({line[17], busy[17]} !== 2'b01) begin
            bad++;
            $display("FAIL arst_pre dout/busy got=%b required=01", {line[17], busy[17]});
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({obs_dout, obs_ready, obs_busy} !== 3'b110) begin
            bad++;
            $display("FAIL arst_now dout/ready/busy got=%b required=110",
                     {obs_dout, obs_ready, obs_busy});
        end
        #1 rst = 1'b0;
        capture(12, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, line, busy);
        total++;
        if ({line[0 +: 12], busy[0 +: 12]} !== {12'hFFF, 12'h000}) begin
            bad++;
            $display("FAIL arst_after dout=%h busy=%h required dout=fff busy=000",
                     line[0 +: 12], busy[0 +: 12]);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_parity();
        test_msb_first();
        test_back_to_back();
        test_ignore_while_busy();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
